// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared fixed-point widths, saturation limits and FSM state encoding
package nn_pkg;
  localparam int SIZE  = 16;
  localparam int N_IN  = 8;
  localparam int FRAC  = 8;
  localparam int IDX_W = $clog2(N_IN);
  localparam int CNT_W = $clog2(N_IN + 1);

  localparam logic signed [SIZE-1:0] SAT_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic signed [SIZE-1:0] SAT_MIN = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;
endpackage

// File: rtl/pu_backprop_if.sv
// rtl/pu_backprop_if.sv - weight input stream and error output stream bundle
interface pu_backprop_if;
  import nn_pkg::*;

  logic             w_valid;
  logic             w_ready;
  logic [SIZE-1:0]  w_data;
  logic             err_valid;
  logic             err_ready;
  logic [SIZE-1:0]  err_data;
  logic [IDX_W-1:0] err_idx;

  modport master (
    output w_valid, w_data, err_ready,
    input  w_ready, err_valid, err_data, err_idx
  );

  modport slave (
    input  w_valid, w_data, err_ready,
    output w_ready, err_valid, err_data, err_idx
  );
endinterface

// File: rtl/fx_mul_sat.sv
// rtl/fx_mul_sat.sv - combinational signed fixed-point multiply, floor shift by F, saturate to W bits
module fx_mul_sat #(
  parameter int W = nn_pkg::SIZE,
  parameter int F = nn_pkg::FRAC
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);
  localparam logic signed [2*W-1:0] HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;

  assign prod    = (2*W)'(a_i) * (2*W)'(b_i);
  assign shifted = prod >>> F;

  always_comb begin
    y_o = shifted[W-1:0];
    if (shifted > HI) begin
      y_o = HI[W-1:0];
    end else if (shifted < LO) begin
      y_o = LO[W-1:0];
    end
  end
endmodule

// File: rtl/pu_backprop.sv
// rtl/pu_backprop.sv - backward pass unit: streams err[i] = sat(w[i] * delta) for N_IN weights
// Optional build macro PU_BACKPROP_RELU_DERIV_EN zeroes delta for a pass whose preact is negative.
module pu_backprop
  import nn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] delta,
  input  logic [SIZE-1:0] preact,
  output logic            busy,
  output logic            done,
  pu_backprop_if.slave    bus
);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(N_IN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
  logic signed [SIZE-1:0] delta_eff_q, delta_eff_d;
  logic [SIZE-1:0]        preact_q, preact_d;
  logic                   err_valid_q, err_valid_d;
  logic [SIZE-1:0]        err_data_q, err_data_d;
  logic [IDX_W-1:0]       err_idx_q, err_idx_d;

  logic signed [SIZE-1:0] term;
  logic signed [SIZE-1:0] start_eff;
  logic                   w_ready, xfer, accept;
  logic                   unused_preact;

`ifdef PU_BACKPROP_RELU_DERIV_EN
  assign start_eff = preact[SIZE-1] ? '0 : delta;
`else
  assign start_eff = delta;
`endif
  // preact is kept for observability of the pass; the ReLU decision is taken at start
  assign unused_preact = ^preact_q;

  fx_mul_sat #(.W(SIZE), .F(FRAC)) u_mul (
    .a_i (bus.w_data),
    .b_i (delta_eff_q),
    .y_o (term)
  );

  // Output register frees up whenever it is empty or being drained this cycle
  assign w_ready = (state_q == RUN) && (in_cnt_q < CNT_END) && (!err_valid_q || bus.err_ready);
  assign xfer    = bus.w_valid && w_ready;
  assign accept  = err_valid_q && bus.err_ready;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    delta_eff_d = delta_eff_q;
    preact_d    = preact_q;
    err_valid_d = err_valid_q;
    err_data_d  = err_data_q;
    err_idx_d   = err_idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          in_cnt_d    = '0;
          delta_eff_d = start_eff;
          preact_d    = preact;
        end
      end
      RUN: begin
        if (xfer) begin
          err_valid_d = 1'b1;
          err_data_d  = term;
          err_idx_d   = in_cnt_q[IDX_W-1:0];
          in_cnt_d    = in_cnt_q + CNT_W'(1);
        end else if (accept) begin
          err_valid_d = 1'b0;
        end
        if (accept && (err_idx_q == IDX_LAST)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      delta_eff_q <= '0;
      preact_q    <= '0;
      err_valid_q <= 1'b0;
      err_data_q  <= '0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      delta_eff_q <= delta_eff_d;
      preact_q    <= preact_d;
      err_valid_q <= err_valid_d;
      err_data_q  <= err_data_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign bus.w_ready   = w_ready;
  assign bus.err_valid = err_valid_q;
  assign bus.err_data  = err_data_q;
  assign bus.err_idx   = err_idx_q;
endmodule

// File: doc/pu_backprop.md
Name: pu_backprop

Overview:
- Backward-pass companion to the 8-input forward neuron processing unit.
- Takes one output-error term (delta) and streams back the 8 input-error terms err[i] = w[i] * delta, one per cycle, over a valid/ready interface.
- Sits between the layer's error source and the previous layer's error accumulator.
- Uses one shared fixed-point multiplier, so throughput is one term per cycle.

Parameters:
- size, 16, data width of delta, weights, preact and error terms (signed two's complement).
- N_IN, 8, number of neuron inputs, i.e. terms per pass.
- FRAC, 8, fractional bits; Q(size-FRAC).FRAC format.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  pulse that begins a pass; sampled only in IDLE.
- delta  input  size  output-error term, latched on accepted start.
- preact  input  size  forward pre-activation sum, latched on accepted start; used only with the optional feature.
- busy  output  1  high from accepted start until done.
- w_valid  input  1  weight word valid.
- w_ready  output  1  unit accepts a weight word this cycle.
- w_data  input  size  weight w[i], supplied in index order 0..N_IN-1.
- err_valid  output  1  err_data/err_idx valid.
- err_ready  input  1  downstream accepts the error term.
- err_data  output  size  err[i], saturated.
- err_idx  output  $clog2(N_IN)  index i of err_data.
- done  output  1  one-cycle pulse after the last term is accepted.

Behaviour:
- Reset: rst=1 at a clock edge clears state to IDLE and all counters. busy=0, w_ready=0, err_valid=0, err_data=0, err_idx=0, done=0. Applies mid-pass as well; the partial pass is discarded.
- States:
  - IDLE: start=1 latches delta and preact, goes to RUN, sets busy=1.
  - RUN: streams weights to error terms (rules below).
  - DONE: 1 cycle; done=1, busy=0; then returns to IDLE.
- start is ignored while busy=1.
- RUN, input side:
  - w_ready = (in_cnt < N_IN) && (!err_valid || err_ready).
  - A weight transfer occurs when w_valid && w_ready.
- RUN, output side:
  - On a transfer, the next edge registers err_data = sat(w_data * delta_eff >>> FRAC), err_idx = in_cnt, err_valid = 1, and increments in_cnt. Latency is 1 cycle.
  - err_valid stays high and err_data/err_idx hold stable until err_ready=1.
  - A simultaneous accept and new transfer replaces the output in the same edge with no bubble.
  - An accept with no new transfer clears err_valid.
- End of pass: when the term with err_idx=N_IN-1 is accepted, the next state is DONE.
- Arithmetic:
  - Full 2*size signed product, then arithmetic right shift by FRAC (floor rounding).
  - Saturate to [-2^(size-1), 2^(size-1)-1].
  - delta_eff = latched delta unless modified by the optional feature.
- Boundary conditions:
  - delta=0 yields all-zero terms.
  - Extreme weights saturate; they never wrap.
  - w_valid while in IDLE or DONE is ignored (w_ready=0).
  - err_ready held low stalls indefinitely with no data loss.

Optional Feature:
- Macro: PU_BACKPROP_RELU_DERIV_EN.
- Defined: applies the ReLU derivative.
  - delta_eff = 0 when the latched preact is negative (MSB=1), else delta.
  - Decision is made once per pass, at start.
- Undefined: delta_eff = delta always; preact is latched but unused.
- Port list is identical in both builds.

Decomposition:
- Shared package nn_pkg holds:
  - SIZE, N_IN and FRAC defaults.
  - SAT_MAX/SAT_MIN constants.
  - State encoding typedef (IDLE, RUN, DONE).
- One natural sub-module: fx_mul_sat, a combinational signed multiply, shift by FRAC and saturate. It is reusable by the forward multipliers.

Test Plan:
- Identity: delta=0x0100 (1.0), weights 0x0100,0x0200,...,0x0800 with err_ready=1 -> err_data equals each weight, err_idx 0..7 on consecutive cycles; done pulses 1 cycle after idx 7 is accepted.
- Saturation: delta=0x0200 (2.0), w=0x7000 -> 0x7FFF; w=0x9000 -> 0x8000; w=0xFF80 (-0.5) -> 0xFF00.
- Backpressure: err_ready=0 for 5 cycles at idx 3 -> err_data/err_idx hold, w_ready=0, no term lost or duplicated; total 8 outputs.
- Start and idle ignore:
  - start pulsed at idx 4 -> ignored, pass completes normally.
  - w_valid in IDLE -> no output.
- Reset mid-pass: rst after 3 terms -> next cycle all outputs at reset values; a fresh pass runs correctly from idx 0.
- Feature: preact=0xFF00, delta=0x0100 -> all err_data=0 with the macro defined, err_data=weights without it; preact=0x0100 -> weights in both builds.
